// File: rtl/dice_result_receiver_if.sv
// Dice result receiver bus.
// Groups the signals shared with the dice and the board logic.
//   button       : roll button, high while rolling
//   throw        : dice value, legal 1..6
//   face_sel     : statistics read select, 1..6
//   result       : last captured throw
//   pips         : 7-LED pattern for result
//   result_valid : one-cycle strobe on a legal capture
//   error        : sticky illegal-capture flag
//   busy         : receiver is in ROLLING or HOLD
//   face_count   : capture count for face_sel
//   total        : total legal captures
// master = the driving side (dice/board), slave = the receiver.
interface dice_result_receiver_if #(
    parameter int CNT_W = 8
);
    logic             button;
    logic [2:0]       throw;
    logic [2:0]       face_sel;
    logic [2:0]       result;
    logic [6:0]       pips;
    logic             result_valid;
    logic             error;
    logic             busy;
    logic [CNT_W-1:0] face_count;
    logic [CNT_W-1:0] total;

    modport master (
        output button, throw, face_sel,
        input  result, pips, result_valid, error, busy, face_count, total
    );

    modport slave (
        input  button, throw, face_sel,
        output result, pips, result_valid, error, busy, face_count, total
    );
endinterface

// File: rtl/dice_result_receiver.sv
// Dice result receiver.
// Watches the roll button and the dice throw bus, captures the throw when the
// button is released, drives the pip pattern and a valid strobe, and keeps
// per-face and total roll statistics.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : dice_result_receiver_if slave modport
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a fresh 0->1 press of the button
// ROLLING | button held; the throw is captured on release
// HOLD    | result held for HOLD_CYCLES cycles, button ignored
module dice_result_receiver #(
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dice_result_receiver_if.slave bus
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             button_d;
    logic [HW-1:0]    hold_cnt;
    logic             capture;
    logic             legal;

    logic [2:0]       result_q;
    logic [6:0]       pips_q;
    logic             valid_q;
    logic             error_q;
    logic [CNT_W-1:0] face_cnt [0:5];
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] face_rd;

    function automatic logic [6:0] pip_decode(input logic [2:0] v);
        logic [6:0] p;
        case (v)
            3'd1:    p = 7'h08;
            3'd2:    p = 7'h41;
            3'd3:    p = 7'h49;
            3'd4:    p = 7'h63;
            3'd5:    p = 7'h6B;
            3'd6:    p = 7'h77;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    assign legal = (bus.throw != 3'd0) && (bus.throw != 3'd7);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // only an observed 0->1 transition starts a roll
                if (bus.button && !button_d) state_nxt = ROLLING;
            end
            ROLLING: begin
                if (!bus.button) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            button_d <= 1'b0;
        end else begin
            state    <= state_nxt;
            button_d <= bus.button;
        end
    end

    // loaded with HOLD_CYCLES-1 so HOLD lasts exactly HOLD_CYCLES cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (capture) begin
            hold_cnt <= HW'(HOLD_CYCLES - 1);
        end else if (state == HOLD && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= 3'd0;
            pips_q   <= 7'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            valid_q <= capture && legal;
            if (capture) begin
                result_q <= bus.throw;
                pips_q   <= legal ? pip_decode(bus.throw) : 7'd0;
                if (!legal) error_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 6; i++) face_cnt[i] <= '0;
            total_q <= '0;
        end else if (capture && legal) begin
            // saturating counters
            if (total_q != '1) total_q <= total_q + CNT_W'(1);
            for (int i = 0; i < 6; i++) begin
                if (bus.throw == 3'(i + 1) && face_cnt[i] != '1)
                    face_cnt[i] <= face_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        face_rd = '0;
        for (int i = 0; i < 6; i++) begin
            if (bus.face_sel == 3'(i + 1)) face_rd = face_cnt[i];
        end
    end

    assign bus.result       = result_q;
    assign bus.pips         = pips_q;
    assign bus.result_valid = valid_q;
    assign bus.error        = error_q;
    assign bus.busy         = (state != IDLE);
    assign bus.face_count   = face_rd;
    assign bus.total        = total_q;

endmodule

// File: tb/tb_dice_result_receiver.sv
module tb_dice_result_receiver;

    localparam int H  = 8;
    localparam int H2 = 2;

    logic clk;
    logic rst;

    dice_result_receiver_if #(.CNT_W(8)) bus ();
    dice_result_receiver_if #(.CNT_W(2)) bus2 ();

    dice_result_receiver #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    dice_result_receiver #(.HOLD_CYCLES(H2), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // reference model: what the dice display should show and how many rolls were seen
    logic [6:0] pip_tab [0:7];
    int         m_face  [1:6];
    int         m_total;
    logic [2:0] m_result;
    logic [6:0] m_pips;
    logic       m_error;

    function automatic bit is_legal(input logic [2:0] v);
        return (v >= 3'd1 && v <= 3'd6);
    endfunction

    function automatic logic [7:0] exp_face(input logic [2:0] sel);
        if (sel >= 3'd1 && sel <= 3'd6) return 8'(m_face[sel]);
        return 8'd0;
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= 6; i++) m_face[i] = 0;
        m_total  = 0;
        m_result = 3'd0;
        m_pips   = 7'd0;
        m_error  = 1'b0;
    endtask

    task automatic model_capture(input logic [2:0] tv);
        m_result = tv;
        if (is_legal(tv)) begin
            m_pips = pip_tab[tv];
            if (m_face[tv] < 255) m_face[tv] = m_face[tv] + 1;
            if (m_total < 255) m_total = m_total + 1;
        end else begin
            m_pips  = 7'd0;
            m_error = 1'b1;
        end
    endtask

    // mode 0: no button during HOLD; 1: press mid-HOLD and keep held;
    // 2: press in the last HOLD cycle and keep held
    task automatic do_roll(input int press, input logic [2:0] tv, input int mode);
        int         n;
        bit         saw_busy;
        bit         saw_valid;
        logic [7:0] tot_before;
        @(negedge clk);
        bus.button = 1'b1;
        bus.throw  = 3'($urandom_range(1, 6));
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rolling_busy got=%0b exp=1", bus.busy);
        end
        for (int i = 1; i < press; i++) begin
            bus.throw = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        bus.button = 1'b0;
        bus.throw  = tv;
        @(negedge clk);
        model_capture(tv);
        bus.face_sel = 3'($urandom_range(0, 7));
        #1;
        vectors++;
        if (bus.result !== m_result) begin
            miscompares++;
            $display("FAIL result got=%0d exp=%0d", bus.result, m_result);
        end
        vectors++;
        if (bus.pips !== m_pips) begin
            miscompares++;
            $display("FAIL pips got=%h exp=%h", bus.pips, m_pips);
        end
        vectors++;
        if (bus.result_valid !== is_legal(tv)) begin
            miscompares++;
            $display("FAIL valid_pulse got=%0b exp=%0b", bus.result_valid, is_legal(tv));
        end
        vectors++;
        if (bus.error !== m_error) begin
            miscompares++;
            $display("FAIL error got=%0b exp=%0b", bus.error, m_error);
        end
        vectors++;
        if (bus.total !== 8'(m_total)) begin
            miscompares++;
            $display("FAIL total got=%0d exp=%0d", bus.total, m_total);
        end
        vectors++;
        if (bus.face_count !== exp_face(bus.face_sel)) begin
            miscompares++;
            $display("FAIL face_count sel=%0d got=%0d exp=%0d", bus.face_sel, bus.face_count,
                     exp_face(bus.face_sel));
        end
        @(negedge clk);
        vectors++;
        if (bus.result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL valid_one_cycle got=%0b exp=0", bus.result_valid);
        end
        n = 1;
        while (bus.busy === 1'b1 && n < 50) begin
            n++;
            if (mode == 1 && n == 3) bus.button = 1'b1;
            if (mode == 2 && n == H) bus.button = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (n !== H) begin
            miscompares++;
            $display("FAIL hold_dwell got=%0d exp=%0d", n, H);
        end
        if (mode != 0) begin
            tot_before = 8'(m_total);
            saw_busy   = 1'b0;
            saw_valid  = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (bus.busy !== 1'b0) saw_busy = 1'b1;
                if (bus.result_valid !== 1'b0) saw_valid = 1'b1;
            end
            vectors++;
            if (saw_busy || saw_valid) begin
                miscompares++;
                $display("FAIL held_button_restart busy=%0b valid=%0b exp=0,0", saw_busy, saw_valid);
            end
            vectors++;
            if (bus.total !== tot_before) begin
                miscompares++;
                $display("FAIL held_button_total got=%0d exp=%0d", bus.total, tot_before);
            end
            bus.button = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({bus.result, bus.pips, bus.result_valid, bus.error, bus.busy, bus.total,
             bus.face_count} !== '0) begin
            miscompares++;
            $display("FAIL %s res=%0d pips=%h v=%0b err=%0b busy=%0b tot=%0d fc=%0d exp=all 0",
                     tag, bus.result, bus.pips, bus.result_valid, bus.error, bus.busy,
                     bus.total, bus.face_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.face_sel = 3'd1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        vectors++;
        if ({bus2.busy, bus2.total} !== '0) begin
            miscompares++;
            $display("FAIL reset_sat busy=%0b total=%0d exp=0", bus2.busy, bus2.total);
        end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single_roll();
        do_roll(5, 3'd4, 0);
    endtask

    task automatic test_six_faces();
        for (int f = 1; f <= 6; f++) do_roll(2, 3'(f), 0);
        for (int f = 0; f <= 7; f++) begin
            bus.face_sel = 3'(f);
            #1;
            vectors++;
            if (bus.face_count !== exp_face(3'(f))) begin
                miscompares++;
                $display("FAIL six_faces sel=%0d got=%0d exp=%0d", f, bus.face_count,
                         exp_face(3'(f)));
            end
        end
    endtask

    task automatic test_press_during_hold();
        do_roll(3, 3'd2, 1);
        do_roll(1, 3'd5, 2);
        do_roll(2, 3'd6, 0);
    endtask

    task automatic test_illegal();
        do_roll(2, 3'd0, 0);
        do_roll(3, 3'd7, 0);
        do_roll(1, 3'd3, 0);
    endtask

    task automatic test_saturation();
        int e;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus2.button = 1'b1;
            repeat (2) @(negedge clk);
            bus2.button = 1'b0;
            bus2.throw  = 3'd3;
            @(negedge clk);
            bus2.face_sel = 3'd3;
            #1;
            e = (i < 3) ? i : 3;
            vectors++;
            if (bus2.face_count !== 2'(e)) begin
                miscompares++;
                $display("FAIL sat_face i=%0d got=%0d exp=%0d", i, bus2.face_count, e);
            end
            vectors++;
            if (bus2.total !== 2'(e)) begin
                miscompares++;
                $display("FAIL sat_total i=%0d got=%0d exp=%0d", i, bus2.total, e);
            end
            repeat (3) @(negedge clk);
            vectors++;
            if (bus2.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL sat_hold_end got=%0b exp=0", bus2.busy);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] tv;
        repeat (16) begin
            if ($urandom_range(0, 9) < 8) tv = 3'($urandom_range(1, 6));
            else tv = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'd0;
            do_roll($urandom_range(1, 6), tv, 0);
        end
    endtask

    task automatic test_async_reset();
        // abort during ROLLING
        bus.face_sel = 3'd4;
        @(negedge clk);
        bus.button = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("rst_mid_rolling");
        model_reset();
        bus.button = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_roll(2, 3'd1, 0);
        // abort during HOLD
        @(negedge clk);
        bus.button = 1'b1;
        repeat (2) @(negedge clk);
        bus.button = 1'b0;
        bus.throw  = 3'd5;
        repeat (2) @(negedge clk);
        bus.face_sel = 3'd1;
        #2 rst = 1'b0;
        #1 check_all_zero("rst_mid_hold");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        do_roll(3, 3'd6, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pip_tab[0] = 7'h00; pip_tab[1] = 7'h08; pip_tab[2] = 7'h41; pip_tab[3] = 7'h49;
        pip_tab[4] = 7'h63; pip_tab[5] = 7'h6B; pip_tab[6] = 7'h77; pip_tab[7] = 7'h00;
        model_reset();
        bus.button    = 1'b0;
        bus.throw     = 3'd0;
        bus.face_sel  = 3'd0;
        bus2.button   = 1'b0;
        bus2.throw    = 3'd0;
        bus2.face_sel = 3'd0;

        test_reset();
        test_single_roll();
        test_six_faces();
        test_press_during_hold();
        test_illegal();
        test_saturation();
        test_random();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dice_result_receiver.md
Name: dice_result_receiver

Overview:
- Sink-side partner of the electronic dice.
- Watches the shared button and the dice's 3-bit throw bus, and captures the final value when the button is released.
- Drives a 7-LED pip pattern and a one-cycle valid strobe, and keeps per-face and total roll statistics.
- Sits between the dice and the board display/LED logic, on the same clock.

Parameters:
- HOLD_CYCLES, 8, cycles the result is held (new rolls ignored) after a capture; must be >= 1.
- CNT_W, 8, width of each per-face counter and of the total counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low; all state cleared while low.
- button  input  1  same roll button that drives the dice; high = rolling.
- throw  input  3  dice output; legal values 1..6.
- face_sel  input  3  statistics read select, 1..6.
- result  output  3  last captured throw.
- pips  output  7  LED pattern for result: bit0 TL, bit1 TR, bit2 ML, bit3 C, bit4 MR, bit5 BL, bit6 BR.
- result_valid  output  1  one-cycle pulse when a legal result is captured.
- error  output  1  sticky flag, set on capture of an illegal throw (0 or 7).
- busy  output  1  high in ROLLING and HOLD.
- face_count  output  CNT_W  capture count for face_sel.
- total  output  CNT_W  total legal captures.

Behaviour:
- Reset (rst low, async):
  - state = IDLE; button_d = 0.
  - result = 0, pips = 0, result_valid = 0, error = 0, busy = 0.
  - All six face counters = 0; total = 0; hold counter = 0.
- button_d: registered copy of button, updated every cycle.
- FSM states: IDLE, ROLLING, HOLD.
  - IDLE:
    - button=1 && button_d=0 (rising edge) -> ROLLING.
    - Otherwise stay.
    - A button already high on entry to IDLE does not start a roll; a fresh press is required.
  - ROLLING:
    - button=1 -> stay; no output change.
    - button=0 -> capture on that edge: result <= throw; load hold counter with HOLD_CYCLES-1; go to HOLD.
  - HOLD:
    - Decrement the hold counter each cycle.
    - At 0 -> IDLE.
    - Button activity is ignored throughout HOLD.
    - Total dwell in HOLD is exactly HOLD_CYCLES cycles.
- Capture, legal throw (1..6), on the capture edge:
  - result_valid <= 1 for exactly one cycle.
  - Face counter [throw] increments; total increments.
  - pips <= decoded pattern.
- Capture, illegal throw (0 or 7), on the capture edge:
  - result <= throw; pips <= 0; error <= 1 (sticky until reset).
  - No result_valid pulse; no counter update.
  - Still enters HOLD.
- Latency: result, pips and result_valid are visible in the cycle after the first clk edge that samples button=0 in ROLLING.
- Pip decode (hex):
  - 1 = 08, 2 = 41, 3 = 49, 4 = 63, 5 = 6B, 6 = 77.
  - pips is registered and updated only on capture; it holds between captures.
- Counters saturate at 2^CNT_W-1 and never wrap.
- face_count: combinational read of counter [face_sel]; 0 when face_sel is 0 or 7.
- busy = (state != IDLE); combinational from state.
- Mid-operation reset: rst low in ROLLING or HOLD aborts immediately to IDLE with all outputs cleared; no capture occurs.
- Simultaneous events: a rising edge of button in the same cycle HOLD expires is ignored. Leaving HOLD goes to IDLE, and IDLE then needs a 0->1 transition it did not observe, so the user must re-press.

Test Plan:
- Reset, then press button for 5 cycles; throw=4 at release. -> One cycle after release: result=4, pips=7'h63, result_valid=1 for one cycle; face_count(face_sel=4)=1; total=1; busy=1 for HOLD_CYCLES more cycles, then 0.
- Six successive rolls with finals 1,2,3,4,5,6, each preceded by a fresh press after HOLD. -> pips sequence 08,41,49,63,6B,77; each face_count=1; total=6.
- Press again during HOLD, and hold the button through HOLD expiry. -> No new capture, counters unchanged; a new capture happens only after release and re-press.
- Release with throw=0, then with throw=7. -> error=1 and stays 1; result_valid never pulses; total unchanged; pips=0; FSM still passes through HOLD.
- CNT_W=2, eight legal captures of face 3. -> face_count(face_sel=3) saturates at 3; total saturates at 3.
- Assert rst low asynchronously mid-ROLLING, then mid-HOLD. -> All outputs 0 immediately, no clock edge needed; after rst high, the next press/release produces a normal capture with counters starting from 0.
